// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU front-end: default widths,
// controller state encoding, response flag bit positions and ALU op codes.
// Imported by alu_seq_driver and its testbench.
package alu_pkg;

    localparam int ALU_WIDTH = 8;
    localparam int ALU_OP_W  = 3;

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        SETTLE_WAIT = 2'd1,
        RESP        = 2'd2
    } state_e;

    // Bit positions inside rsp_flags = {cout, cflag, zflag}
    localparam int FLAG_COUT = 2;
    localparam int FLAG_C    = 1;
    localparam int FLAG_Z    = 0;

    localparam logic [ALU_OP_W-1:0] OP_ADD = 3'b000;
    localparam logic [ALU_OP_W-1:0] OP_SUB = 3'b001;
    localparam logic [ALU_OP_W-1:0] OP_AND = 3'b010;
    localparam logic [ALU_OP_W-1:0] OP_OR  = 3'b011;
    localparam logic [ALU_OP_W-1:0] OP_XOR = 3'b100;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: sticks at all-ones, never wraps.
// Latency: count reflects inc/clr one cycle after the edge that samples them.
// Backpressure: none; inc is a single-cycle pulse. Ports: clk, rst (sync,
// active-high), inc, clr (sync clear, wins over inc), count.
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (inc && (count_q != '1)) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/alu_seq_driver.sv
// Sequential front-end for a combinational ALU: registers a host request onto
// the ALU inputs, waits SETTLE extra cycles, captures result+flags for the host.
// Latency: rsp_valid rises SETTLE+1 cycles after the request handshake edge.
// Backpressure: one op in flight; req_ready is low until the response handshake
// completes, and the result is held stable while rsp_ready is low.
// Ports: req_* (host request), alu_* (ALU drive/return), rsp_* (host response),
// op_count/zero_count (saturating statistics).
module alu_seq_driver
    import alu_pkg::*;
#(
    parameter int WIDTH  = ALU_WIDTH,
    parameter int OP_W   = ALU_OP_W,
    parameter int SETTLE = 1,
    parameter int CNT_W  = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [WIDTH-1:0] req_a,
    input  logic [WIDTH-1:0] req_b,
    input  logic [OP_W-1:0]  req_op,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [OP_W-1:0]  alu_op,
    input  logic [WIDTH-1:0] alu_out,
    input  logic             alu_cout,
    input  logic             alu_cflag,
    input  logic             alu_zflag,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_out,
    output logic [2:0]       rsp_flags,
    output logic [CNT_W-1:0] op_count,
    output logic [CNT_W-1:0] zero_count
);

    localparam logic [3:0] SETTLE_INIT = 4'(SETTLE);

    state_e           state_q,      state_d;
    logic [WIDTH-1:0] alu_a_q,      alu_a_d;
    logic [WIDTH-1:0] alu_b_q,      alu_b_d;
    logic [OP_W-1:0]  alu_op_q,     alu_op_d;
    logic [3:0]       settle_cnt_q, settle_cnt_d;
    logic             rsp_valid_q,  rsp_valid_d;
    logic [WIDTH-1:0] rsp_out_q,    rsp_out_d;
    logic [2:0]       rsp_flags_q,  rsp_flags_d;
    logic             rsp_hs;

    always_comb begin
        state_d      = state_q;
        alu_a_d      = alu_a_q;
        alu_b_d      = alu_b_q;
        alu_op_d     = alu_op_q;
        settle_cnt_d = settle_cnt_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_out_d    = rsp_out_q;
        rsp_flags_d  = rsp_flags_q;
        req_ready    = 1'b0;

        case (state_q)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    alu_a_d      = req_a;
                    alu_b_d      = req_b;
                    alu_op_d     = req_op;
                    settle_cnt_d = SETTLE_INIT;
                    state_d      = SETTLE_WAIT;
                end
            end
            SETTLE_WAIT: begin
                if (settle_cnt_q != 4'd0) begin
                    settle_cnt_d = settle_cnt_q - 4'd1;
                end else begin
                    rsp_out_d              = alu_out;
                    rsp_flags_d[FLAG_COUT] = alu_cout;
                    rsp_flags_d[FLAG_C]    = alu_cflag;
                    rsp_flags_d[FLAG_Z]    = alu_zflag;
                    rsp_valid_d            = 1'b1;
                    state_d                = RESP;
                end
            end
            RESP: begin
                // req_ready stays low here so a new request can only be
                // taken the cycle after the response handshake.
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            alu_op_q     <= '0;
            settle_cnt_q <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_out_q    <= '0;
            rsp_flags_q  <= '0;
        end else begin
            state_q      <= state_d;
            alu_a_q      <= alu_a_d;
            alu_b_q      <= alu_b_d;
            alu_op_q     <= alu_op_d;
            settle_cnt_q <= settle_cnt_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_out_q    <= rsp_out_d;
            rsp_flags_q  <= rsp_flags_d;
        end
    end

    assign rsp_hs    = rsp_valid_q & rsp_ready;
    assign alu_a     = alu_a_q;
    assign alu_b     = alu_b_q;
    assign alu_op    = alu_op_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_out   = rsp_out_q;
    assign rsp_flags = rsp_flags_q;

    sat_counter #(.CNT_W(CNT_W)) u_op_count (
        .clk   (clk),
        .rst   (rst),
        .inc   (rsp_hs),
        .clr   (1'b0),
        .count (op_count)
    );

    // Uses the captured zflag, not the live ALU input, which may have moved on.
    sat_counter #(.CNT_W(CNT_W)) u_zero_count (
        .clk   (clk),
        .rst   (rst),
        .inc   (rsp_hs & rsp_flags_q[FLAG_Z]),
        .clr   (1'b0),
        .count (zero_count)
    );

endmodule

// File: tb/tb_alu_seq_driver.sv
module tb_alu_seq_driver;
    import alu_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic [7:0] req_a, req_b;
    logic [2:0] req_op;
    logic       req_valid [4];
    logic       rsp_ready [4];

    wire        req_ready_w [4];
    wire        rsp_valid_w [4];
    wire [7:0]  alu_a_w     [4];
    wire [7:0]  alu_b_w     [4];
    wire [7:0]  rsp_out_w   [4];
    wire [2:0]  alu_op_w    [4];
    wire [2:0]  rsp_flags_w [4];
    wire [10:0] alu_res     [4];
    wire [15:0] op_cnt_w    [3];
    wire [15:0] zero_cnt_w  [3];
    wire [3:0]  op_cnt4, zero_cnt4;

    int tests = 0;
    int fails = 0;

    // Behavioural ALU: {cout, cflag, zflag, out[7:0]}; cout/cflag = carry (add) or borrow (sub)
    function automatic logic [10:0] alu_f(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op);
        logic [8:0] r;
        case (op)
            3'b000:  r = {1'b0, a} + {1'b0, b};
            3'b001:  r = {1'b0, a} - {1'b0, b};
            default: r = {1'b0, a & b};
        endcase
        return {r[8], r[8], (r[7:0] == 8'h00), r[7:0]};
    endfunction

    for (genvar i = 0; i < 4; i++) begin : g_alu
        assign alu_res[i] = alu_f(alu_a_w[i], alu_b_w[i], alu_op_w[i]);
    end

    alu_seq_driver #(.SETTLE(1)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid[0]), .req_ready(req_ready_w[0]),
        .req_a(req_a), .req_b(req_b), .req_op(req_op),
        .alu_a(alu_a_w[0]), .alu_b(alu_b_w[0]), .alu_op(alu_op_w[0]),
        .alu_out(alu_res[0][7:0]), .alu_cout(alu_res[0][10]), .alu_cflag(alu_res[0][9]), .alu_zflag(alu_res[0][8]),
        .rsp_valid(rsp_valid_w[0]), .rsp_ready(rsp_ready[0]), .rsp_out(rsp_out_w[0]), .rsp_flags(rsp_flags_w[0]),
        .op_count(op_cnt_w[0]), .zero_count(zero_cnt_w[0]));

    alu_seq_driver #(.SETTLE(0)) dut_s0 (
        .clk(clk), .rst(rst), .req_valid(req_valid[1]), .req_ready(req_ready_w[1]),
        .req_a(req_a), .req_b(req_b), .req_op(req_op),
        .alu_a(alu_a_w[1]), .alu_b(alu_b_w[1]), .alu_op(alu_op_w[1]),
        .alu_out(alu_res[1][7:0]), .alu_cout(alu_res[1][10]), .alu_cflag(alu_res[1][9]), .alu_zflag(alu_res[1][8]),
        .rsp_valid(rsp_valid_w[1]), .rsp_ready(rsp_ready[1]), .rsp_out(rsp_out_w[1]), .rsp_flags(rsp_flags_w[1]),
        .op_count(op_cnt_w[1]), .zero_count(zero_cnt_w[1]));

    alu_seq_driver #(.SETTLE(15)) dut_s15 (
        .clk(clk), .rst(rst), .req_valid(req_valid[2]), .req_ready(req_ready_w[2]),
        .req_a(req_a), .req_b(req_b), .req_op(req_op),
        .alu_a(alu_a_w[2]), .alu_b(alu_b_w[2]), .alu_op(alu_op_w[2]),
        .alu_out(alu_res[2][7:0]), .alu_cout(alu_res[2][10]), .alu_cflag(alu_res[2][9]), .alu_zflag(alu_res[2][8]),
        .rsp_valid(rsp_valid_w[2]), .rsp_ready(rsp_ready[2]), .rsp_out(rsp_out_w[2]), .rsp_flags(rsp_flags_w[2]),
        .op_count(op_cnt_w[2]), .zero_count(zero_cnt_w[2]));

    alu_seq_driver #(.SETTLE(1), .CNT_W(4)) dut_sat (
        .clk(clk), .rst(rst), .req_valid(req_valid[3]), .req_ready(req_ready_w[3]),
        .req_a(req_a), .req_b(req_b), .req_op(req_op),
        .alu_a(alu_a_w[3]), .alu_b(alu_b_w[3]), .alu_op(alu_op_w[3]),
        .alu_out(alu_res[3][7:0]), .alu_cout(alu_res[3][10]), .alu_cflag(alu_res[3][9]), .alu_zflag(alu_res[3][8]),
        .rsp_valid(rsp_valid_w[3]), .rsp_ready(rsp_ready[3]), .rsp_out(rsp_out_w[3]), .rsp_flags(rsp_flags_w[3]),
        .op_count(op_cnt4), .zero_count(zero_cnt4));

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issue one request to DUT d; lat = cycles from accept edge until rsp_valid (40 = timeout)
    task automatic run_op(input int d, input logic [7:0] a, input logic [7:0] b,
                          input logic [2:0] op, output int lat);
        req_a = a; req_b = b; req_op = op;
        req_valid[d] = 1'b1;
        step();
        req_valid[d] = 1'b0;
        lat = 0;
        while (!rsp_valid_w[d] && lat < 40) begin
            step();
            lat++;
        end
    endtask

    task automatic finish_rsp(input int d);
        rsp_ready[d] = 1'b1;
        step();
        rsp_ready[d] = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step(); step();
        rst = 1'b0;
        tests++; if (req_ready_w[0] !== 1'b1) begin fails++; $display("FAIL reset_req_ready got=%b want=1", req_ready_w[0]); end
        tests++; if (rsp_valid_w[0] !== 1'b0) begin fails++; $display("FAIL reset_rsp_valid got=%b want=0", rsp_valid_w[0]); end
        tests++; if (alu_a_w[0] !== 8'h00) begin fails++; $display("FAIL reset_alu_a got=%h want=00", alu_a_w[0]); end
        tests++; if (rsp_out_w[0] !== 8'h00) begin fails++; $display("FAIL reset_rsp_out got=%h want=00", rsp_out_w[0]); end
        tests++; if (rsp_flags_w[0] !== 3'b000) begin fails++; $display("FAIL reset_rsp_flags got=%b want=000", rsp_flags_w[0]); end
        tests++; if (op_cnt_w[0] !== 16'd0) begin fails++; $display("FAIL reset_op_count got=%0d want=0", op_cnt_w[0]); end
        tests++; if (zero_cnt_w[0] !== 16'd0) begin fails++; $display("FAIL reset_zero_count got=%0d want=0", zero_cnt_w[0]); end
    endtask

    task automatic test_basic_add();
        int lat;
        run_op(0, 8'h07, 8'h05, OP_ADD, lat);
        tests++; if (lat != 2) begin fails++; $display("FAIL add_latency got=%0d want=2", lat); end
        tests++; if (alu_a_w[0] !== 8'h07 || alu_b_w[0] !== 8'h05 || alu_op_w[0] !== 3'b000) begin
            fails++; $display("FAIL add_alu_drive got=%h/%h/%b want=07/05/000", alu_a_w[0], alu_b_w[0], alu_op_w[0]); end
        tests++; if (rsp_out_w[0] !== 8'h0C) begin fails++; $display("FAIL add_rsp_out got=%h want=0c", rsp_out_w[0]); end
        tests++; if (rsp_flags_w[0] !== 3'b000) begin fails++; $display("FAIL add_flags got=%b want=000", rsp_flags_w[0]); end
        tests++; if (op_cnt_w[0] !== 16'd0) begin fails++; $display("FAIL add_count_pre got=%0d want=0", op_cnt_w[0]); end
        finish_rsp(0);
        tests++; if (op_cnt_w[0] !== 16'd1) begin fails++; $display("FAIL add_op_count got=%0d want=1", op_cnt_w[0]); end
        tests++; if (rsp_valid_w[0] !== 1'b0) begin fails++; $display("FAIL add_valid_clear got=%b want=0", rsp_valid_w[0]); end
        tests++; if (req_ready_w[0] !== 1'b1) begin fails++; $display("FAIL add_ready_back got=%b want=1", req_ready_w[0]); end
    endtask

    task automatic test_zero();
        int lat;
        run_op(0, 8'h07, 8'h07, OP_SUB, lat);
        tests++; if (lat != 2) begin fails++; $display("FAIL zero_latency got=%0d want=2", lat); end
        tests++; if (rsp_out_w[0] !== 8'h00) begin fails++; $display("FAIL zero_rsp_out got=%h want=00", rsp_out_w[0]); end
        tests++; if (rsp_flags_w[0] !== 3'b001) begin fails++; $display("FAIL zero_flags got=%b want=001", rsp_flags_w[0]); end
        finish_rsp(0);
        tests++; if (zero_cnt_w[0] !== 16'd1) begin fails++; $display("FAIL zero_count got=%0d want=1", zero_cnt_w[0]); end
        tests++; if (op_cnt_w[0] !== 16'd2) begin fails++; $display("FAIL zero_op_count got=%0d want=2", op_cnt_w[0]); end
    endtask

    task automatic test_backpressure();
        int lat;
        run_op(0, 8'h20, 8'h11, OP_ADD, lat);
        tests++; if (lat != 2 || rsp_out_w[0] !== 8'h31) begin
            fails++; $display("FAIL bp_first got lat=%0d out=%h want lat=2 out=31", lat, rsp_out_w[0]); end
        for (int c = 0; c < 10; c++) begin
            if (c == 3) begin req_a = 8'hAA; req_b = 8'h55; req_valid[0] = 1'b1; end
            else req_valid[0] = 1'b0;
            step();
            tests++; if (rsp_valid_w[0] !== 1'b1 || rsp_out_w[0] !== 8'h31 || rsp_flags_w[0] !== 3'b000) begin
                fails++; $display("FAIL bp_hold cyc=%0d got valid=%b out=%h flags=%b want 1/31/000", c, rsp_valid_w[0], rsp_out_w[0], rsp_flags_w[0]); end
            tests++; if (req_ready_w[0] !== 1'b0) begin fails++; $display("FAIL bp_req_ready cyc=%0d got=%b want=0", c, req_ready_w[0]); end
        end
        req_valid[0] = 1'b0;
        tests++; if (alu_a_w[0] !== 8'h20 || alu_b_w[0] !== 8'h11) begin
            fails++; $display("FAIL bp_ignored_req got=%h/%h want=20/11", alu_a_w[0], alu_b_w[0]); end
        finish_rsp(0);
        tests++; if (rsp_valid_w[0] !== 1'b0 || req_ready_w[0] !== 1'b1) begin
            fails++; $display("FAIL bp_release got valid=%b ready=%b want 0/1", rsp_valid_w[0], req_ready_w[0]); end
        tests++; if (op_cnt_w[0] !== 16'd3 || zero_cnt_w[0] !== 16'd1) begin
            fails++; $display("FAIL bp_counts got=%0d/%0d want=3/1", op_cnt_w[0], zero_cnt_w[0]); end
        step(); step(); step();
        tests++; if (rsp_valid_w[0] !== 1'b0 || req_ready_w[0] !== 1'b1) begin
            fails++; $display("FAIL bp_no_extra got valid=%b ready=%b want 0/1", rsp_valid_w[0], req_ready_w[0]); end
    endtask

    task automatic test_reset_mid();
        bit seen = 1'b0;
        req_a = 8'h33; req_b = 8'h22; req_op = OP_ADD;
        req_valid[0] = 1'b1;
        step();
        req_valid[0] = 1'b0;
        tests++; if (req_ready_w[0] !== 1'b0) begin fails++; $display("FAIL mid_in_settle got=%b want=0", req_ready_w[0]); end
        rst = 1'b1;
        step();
        rst = 1'b0;
        tests++; if (req_ready_w[0] !== 1'b1 || rsp_valid_w[0] !== 1'b0) begin
            fails++; $display("FAIL mid_state got ready=%b valid=%b want 1/0", req_ready_w[0], rsp_valid_w[0]); end
        tests++; if (alu_a_w[0] !== 8'h00) begin fails++; $display("FAIL mid_alu_a got=%h want=00", alu_a_w[0]); end
        tests++; if (op_cnt_w[0] !== 16'd0 || zero_cnt_w[0] !== 16'd0) begin
            fails++; $display("FAIL mid_counts got=%0d/%0d want=0/0", op_cnt_w[0], zero_cnt_w[0]); end
        for (int c = 0; c < 20; c++) begin
            step();
            if (rsp_valid_w[0]) seen = 1'b1;
        end
        tests++; if (seen !== 1'b0) begin fails++; $display("FAIL mid_no_rsp got=%b want=0", seen); end
    endtask

    task automatic test_back_to_back();
        int n = 0;
        req_a = 8'h03; req_b = 8'h04; req_op = OP_ADD;
        req_valid[0] = 1'b1;
        rsp_ready[0] = 1'b1;
        for (int c = 0; c < 40; c++) begin
            step();
            if (rsp_valid_w[0]) n++;
        end
        req_valid[0] = 1'b0;
        rsp_ready[0] = 1'b0;
        tests++; if (n != 10) begin fails++; $display("FAIL b2b_rsp_count got=%0d want=10", n); end
        tests++; if (op_cnt_w[0] !== 16'd10 || zero_cnt_w[0] !== 16'd0) begin
            fails++; $display("FAIL b2b_counts got=%0d/%0d want=10/0", op_cnt_w[0], zero_cnt_w[0]); end
    endtask

    task automatic test_settle_latency();
        int lat;
        run_op(1, 8'hFF, 8'h01, OP_ADD, lat);
        tests++; if (lat != 1) begin fails++; $display("FAIL settle0_latency got=%0d want=1", lat); end
        tests++; if (rsp_out_w[1] !== 8'h00 || rsp_flags_w[1] !== 3'b111) begin
            fails++; $display("FAIL settle0_result got=%h/%b want=00/111", rsp_out_w[1], rsp_flags_w[1]); end
        finish_rsp(1);
        run_op(2, 8'h05, 8'h07, OP_SUB, lat);
        tests++; if (lat != 16) begin fails++; $display("FAIL settle15_latency got=%0d want=16", lat); end
        tests++; if (rsp_out_w[2] !== 8'hFE || rsp_flags_w[2] !== 3'b110) begin
            fails++; $display("FAIL settle15_result got=%h/%b want=fe/110", rsp_out_w[2], rsp_flags_w[2]); end
        finish_rsp(2);
        tests++; if (op_cnt_w[1] !== 16'd1 || op_cnt_w[2] !== 16'd1) begin
            fails++; $display("FAIL settle_counts got=%0d/%0d want=1/1", op_cnt_w[1], op_cnt_w[2]); end
    endtask

    task automatic test_saturation();
        int lat;
        int bad = 0;
        for (int i = 0; i < 20; i++) begin
            run_op(3, 8'(i), 8'(i), OP_SUB, lat);
            if (lat != 2) bad++;
            finish_rsp(3);
            if (i == 14) begin
                tests++; if (op_cnt4 !== 4'hF) begin fails++; $display("FAIL sat_at15 got=%h want=f", op_cnt4); end
            end
        end
        tests++; if (bad != 0) begin fails++; $display("FAIL sat_latency got=%0d bad want=0", bad); end
        tests++; if (op_cnt4 !== 4'hF || zero_cnt4 !== 4'hF) begin
            fails++; $display("FAIL sat_final got=%h/%h want=f/f", op_cnt4, zero_cnt4); end
    endtask

    initial begin
        rst = 1'b1;
        req_a = '0; req_b = '0; req_op = '0;
        for (int i = 0; i < 4; i++) begin
            req_valid[i] = 1'b0;
            rsp_ready[i] = 1'b0;
        end
        test_reset();
        test_basic_add();
        test_zero();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        test_settle_latency();
        test_saturation();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/alu_seq_driver.md
Name: alu_seq_driver

Overview:
- Sequential front-end for the combinational ALU (ports a, b, op_code, out, carry_out, c_flag, zero_flag).
- Accepts operation requests from a host over valid/ready and drives the ALU inputs from registers.
- Waits a programmable settle time, then captures the ALU result and flags and returns them to the host over valid/ready.
- Also keeps saturating statistics counters for operations completed and zero results.

Parameters:
- WIDTH, 8, operand/result width; must match the ALU.
- OP_W, 3, op_code width.
- SETTLE, 1, number of extra cycles to wait after the ALU inputs change before capture; legal range 0..15.
- CNT_W, 16, width of the statistics counters.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  host request valid.
- req_ready  out  1  block can accept a request.
- req_a  in  WIDTH  operand a.
- req_b  in  WIDTH  operand b.
- req_op  in  OP_W  op_code.
- alu_a  out  WIDTH  registered drive to ALU a.
- alu_b  out  WIDTH  registered drive to ALU b.
- alu_op  out  OP_W  registered drive to ALU op_code.
- alu_out  in  WIDTH  from ALU out.
- alu_cout  in  1  from ALU carry_out.
- alu_cflag  in  1  from ALU c_flag.
- alu_zflag  in  1  from ALU zero_flag.
- rsp_valid  out  1  captured result valid.
- rsp_ready  in  1  host accepts result.
- rsp_out  out  WIDTH  captured result.
- rsp_flags  out  3  {cout, cflag, zflag} as captured.
- op_count  out  CNT_W  completed responses (saturating).
- zero_count  out  CNT_W  completed responses with zflag=1 (saturating).

Behaviour:
- Reset (rst=1 at an edge) forces the following, regardless of state, including mid-operation; in-flight requests are discarded:
  - state=IDLE
  - alu_a, alu_b, alu_op = 0
  - rsp_valid=0, rsp_out=0, rsp_flags=0
  - op_count=0, zero_count=0
  - settle counter=0
- FSM states: IDLE, SETTLE_WAIT, RESP.
- IDLE:
  - req_ready=1 (combinational from state only).
  - On req_valid & req_ready at edge N: register req_a/b/op onto alu_a/b/op, load settle counter with SETTLE, go to SETTLE_WAIT.
- SETTLE_WAIT:
  - req_ready=0.
  - If counter≠0, decrement.
  - If counter==0: capture alu_out→rsp_out and {alu_cout, alu_cflag, alu_zflag}→rsp_flags, set rsp_valid=1, go to RESP.
  - Capture occurs at edge N+1+SETTLE.
  - Latency from request handshake edge to rsp_valid high is SETTLE+1 cycles.
- RESP:
  - rsp_valid=1; rsp_out and rsp_flags are held stable until the handshake.
  - On rsp_valid & rsp_ready: clear rsp_valid, increment op_count (saturate at all-ones), increment zero_count if captured zflag=1 (saturate), go to IDLE.
  - No new request is accepted in the same cycle as the response handshake; req_ready rises the following cycle.
- alu_a/b/op hold their last value in every state; they change only on request accept or reset.
- req_* inputs are ignored whenever req_ready=0.
- Counters at all-ones stay at all-ones and never wrap.
- rsp_ready held high continuously gives a throughput of one op per SETTLE+3 cycles.

Decomposition:
- Shared package alu_pkg holds:
  - WIDTH/OP_W defaults
  - FSM state enum (IDLE, SETTLE_WAIT, RESP)
  - flag bit indices (FLAG_COUT=2, FLAG_C=1, FLAG_Z=0)
  - ALU op_code constants
- One natural sub-module: sat_counter (CNT_W parameter, inc/clear, saturating), instantiated twice for op_count and zero_count.
- The FSM stays in the top level.

Test Plan:
- Bench uses a behavioural ALU with op 000 = add, 001 = sub.
- Basic add: rst 2 cycles, SETTLE=1, req a=0x07 b=0x05 op=000 → rsp_valid 2 cycles after accept, rsp_out=0x0C, rsp_flags zflag=0; op_count=1 after handshake.
- Zero result: a=0x07 b=0x07 op=001 → rsp_out=0x00, zflag=1; zero_count increments to 1.
- Backpressure: hold rsp_ready=0 for 10 cycles → rsp_valid stays 1, rsp_out stable, req_ready=0, a req_valid pulse with new operands is ignored; then rsp_ready=1 → one handshake, then req_ready=1 the next cycle.
- Reset mid-operation: assert rst in SETTLE_WAIT → next cycle state=IDLE, rsp_valid=0, alu_a=0, counters=0; no response ever appears for the aborted request.
- SETTLE=0 and SETTLE=15 builds: measured accept→rsp_valid latency equals 1 and 16 cycles respectively.
- Saturation: with CNT_W=4, complete 20 ops all producing zero → op_count=zero_count=0xF.
